// File: rtl/gfx_bus_pkg.sv
// Shared definitions for the graphics bus master: FSM encoding, transfer width codes
// and default bus geometry.
package gfx_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCyc,
    StRel
  } state_e;

  // Transfer width codes, passed to the bus unchanged.
  localparam logic [3:0] WidthByte  = 4'd0;
  localparam logic [3:0] WidthHalf  = 4'd1;
  localparam logic [3:0] WidthWord  = 4'd2;
  localparam logic [3:0] WidthDword = 4'd3;

  localparam int unsigned DefAw = 24;
  localparam int unsigned DefDw = 64;
  localparam int unsigned DefWw = 4;

endpackage

// File: rtl/gfx_rr_arb.sv
// Combinational NCH-way round-robin picker: searches upward from ptr (wrapping) for the
// first request not blocked by mask.
module gfx_rr_arb #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic [NCH-1:0] mask,
  output logic [NCH-1:0] gnt_oh,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_valid
);

  logic [NCH-1:0] elig;
  assign elig = req & ~mask;

  // First eligible requester at or after the pointer.
  always_comb begin
    logic [IW-1:0] j;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      j = IW'((int'(ptr) + k) % int'(NCH));
      if (!gnt_valid && elig[j]) begin
        gnt_valid  = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = j;
      end
    end
  end

endmodule

// File: rtl/gfx_bus_master.sv
// Bus-master front end for the graphics unit: arbitrates internal channels, owns the
// system bus through breq/back and runs memory cycles on the split tristate bus.
// Optional feature macro: GFX_BUS_LOCK_EN adds ch_lock; a locked channel keeps the bus
// regardless of the burst limit and drives lock.
module gfx_bus_master
  import gfx_bus_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned AW        = DefAw,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned WW        = DefWw,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_read,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*WW-1:0] ch_width,
  input  logic [NCH*DW-1:0] ch_wdata,
`ifdef GFX_BUS_LOCK_EN
  input  logic [NCH-1:0]    ch_lock,
`endif
  output logic [NCH-1:0]    ch_done,
  output logic [DW-1:0]     rdata,
  output logic              breq,
  input  logic              back,
  input  logic              ack,
  input  logic [DW-1:0]     data_in,
  output logic [AW-1:0]     a_out,
  output logic              a_oe,
  output logic [WW-1:0]     width_out,
  output logic              width_oe,
  output logic              read_out,
  output logic              read_oe,
  output logic              mreq_out,
  output logic              mreq_oe,
  output logic [DW-1:0]     wdata_out,
  output logic              wdata_oe,
  output logic              lock
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         state_q;
  logic           gap_q;      // done cycle between bus cycles, mreq low
  logic [IW-1:0]  sel_q;
  logic [IW-1:0]  ptr_q;
  logic [NCH-1:0] mask_q;     // just-completed channel, blocked for one pick
  logic [3:0]     cnt_q;
  logic           bus_oe_q;
  logic           lock_q;

  logic [NCH-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;
  logic           hold_lock;
  logic           pick_lock;
  logic           burst_ok;
  logic           start_cyc;
  logic           go_rel;

  gfx_rr_arb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .req       (ch_req),
    .ptr       (ptr_q),
    .mask      (mask_q),
    .gnt_oh    (pick_oh),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

`ifdef GFX_BUS_LOCK_EN
  assign hold_lock = ch_lock[sel_q];
  assign pick_lock = ch_lock[pick_idx];
`else
  assign hold_lock = 1'b0;
  assign pick_lock = 1'b0;
`endif

  assign a_oe     = bus_oe_q;
  assign width_oe = bus_oe_q;
  assign read_oe  = bus_oe_q;
  assign mreq_oe  = bus_oe_q;
  assign lock     = lock_q;

  // Decide whether to start a bus cycle or give the bus back this cycle.
  always_comb begin
    burst_ok  = (cnt_q < 4'(MAX_BURST)) || hold_lock;
    start_cyc = 1'b0;
    go_rel    = 1'b0;
    unique case (state_q)
      StReq: begin
        start_cyc = back && pick_valid;
        go_rel    = !pick_valid;  // every request withdrawn before selection
      end
      StCyc: begin
        if (gap_q) begin
          start_cyc = back && pick_valid && burst_ok;
          // A locked channel keeps ownership even with nothing pending yet.
          go_rel    = !start_cyc && !(hold_lock && back);
        end
      end
      default: ;
    endcase
  end

  // Bus-master FSM with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gap_q     <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      bus_oe_q  <= 1'b0;
      lock_q    <= 1'b0;
      ch_done   <= '0;
      rdata     <= '0;
      breq      <= 1'b0;
      a_out     <= '0;
      width_out <= '0;
      read_out  <= 1'b0;
      mreq_out  <= 1'b0;
      wdata_out <= '0;
      wdata_oe  <= 1'b0;
    end else begin
      ch_done <= '0;
      mask_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (|ch_req) begin
            state_q <= StReq;
            breq    <= 1'b1;
          end
        end
        StReq: begin
          if (start_cyc) state_q <= StCyc;
          else if (go_rel) state_q <= StRel;
        end
        StCyc: begin
          if (!gap_q && ack) begin
            ch_done[sel_q] <= 1'b1;
            mask_q[sel_q]  <= 1'b1;
            if (read_out) rdata <= data_in;
            ptr_q    <= (sel_q == IW'(NCH - 1)) ? '0 : sel_q + 1'b1;
            if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
            mreq_out <= 1'b0;
            gap_q    <= 1'b1;
          end else if (go_rel) begin
            state_q <= StRel;
          end
        end
        StRel: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase

      if (start_cyc) begin
        gap_q     <= 1'b0;
        sel_q     <= pick_idx;
        bus_oe_q  <= 1'b1;
        mreq_out  <= 1'b1;
        a_out     <= ch_addr[int'(pick_idx)*AW +: AW];
        width_out <= ch_width[int'(pick_idx)*WW +: WW];
        read_out  <= ch_read[pick_idx];
        wdata_out <= ch_wdata[int'(pick_idx)*DW +: DW];
        wdata_oe  <= !ch_read[pick_idx];
        lock_q    <= pick_lock;
      end

      if (go_rel) begin
        gap_q     <= 1'b0;
        breq      <= 1'b0;
        bus_oe_q  <= 1'b0;
        mreq_out  <= 1'b0;
        wdata_oe  <= 1'b0;
        lock_q    <= 1'b0;
        a_out     <= '0;
        width_out <= '0;
        read_out  <= 1'b0;
        wdata_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gfx_bus_master.sv
// Directed self-checking bench for gfx_bus_master (NCH=4, MAX_BURST=4).
module tb_gfx_bus_master;
  import gfx_bus_pkg::*;

  localparam int unsigned NCH       = 4;
  localparam int unsigned AW        = 24;
  localparam int unsigned DW        = 64;
  localparam int unsigned WW        = 4;
  localparam int unsigned MAX_BURST = 4;

  logic              clk;
  logic              reset_n;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_read;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*WW-1:0] ch_width;
  logic [NCH*DW-1:0] ch_wdata;
`ifdef GFX_BUS_LOCK_EN
  logic [NCH-1:0]    ch_lock;
`endif
  logic [NCH-1:0]    ch_done;
  logic [DW-1:0]     rdata;
  logic              breq;
  logic              back;
  logic              ack;
  logic [DW-1:0]     data_in;
  logic [AW-1:0]     a_out;
  logic              a_oe;
  logic [WW-1:0]     width_out;
  logic              width_oe;
  logic              read_out;
  logic              read_oe;
  logic              mreq_out;
  logic              mreq_oe;
  logic [DW-1:0]     wdata_out;
  logic              wdata_oe;
  logic              lock;

  gfx_bus_master #(
    .NCH       (NCH),
    .AW        (AW),
    .DW        (DW),
    .WW        (WW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch_req    (ch_req),
    .ch_read   (ch_read),
    .ch_addr   (ch_addr),
    .ch_width  (ch_width),
    .ch_wdata  (ch_wdata),
`ifdef GFX_BUS_LOCK_EN
    .ch_lock   (ch_lock),
`endif
    .ch_done   (ch_done),
    .rdata     (rdata),
    .breq      (breq),
    .back      (back),
    .ack       (ack),
    .data_in   (data_in),
    .a_out     (a_out),
    .a_oe      (a_oe),
    .width_out (width_out),
    .width_oe  (width_oe),
    .read_out  (read_out),
    .read_oe   (read_oe),
    .mreq_out  (mreq_out),
    .mreq_oe   (mreq_oe),
    .wdata_out (wdata_out),
    .wdata_oe  (wdata_oe),
    .lock      (lock)
  );

  int n_checks;
  int n_errors;
  int remaining [NCH];  // outstanding requests per channel
  int ack_delay;
  int ack_cnt;
  int log_q [$];        // completed channel indices, 9 marks a bus release
  int exp_q [$];
  logic breq_prev;
  int lock_bad;
  bit lock_scn;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_len", tag), 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) check($sformatf("%s[%0d]", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic post(input int ch, input int n);
    remaining[ch] = n;
  endtask

  function automatic bit all_served();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NCH; i++) if (remaining[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NCH; i++) remaining[i] = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    log_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(all_served() && !breq && !a_oe) && n < budget);
    repeat (3) @(negedge clk);
    check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  task automatic wait_mreq(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mreq_out && n < budget);
    check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  // Bus responder, channel requesters and event log, all sampled on the falling edge.
  initial begin
    ack       = 1'b0;
    ack_cnt   = 0;
    breq_prev = 1'b0;
    lock_bad  = 0;
    ch_req    = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ack     = 1'b0;
        ack_cnt = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if (mreq_out) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          ack     = 1'b1;
          ack_cnt = 0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_done[i]) begin
          log_q.push_back(i);
          if (remaining[i] > 0) remaining[i]--;
        end
        ch_req[i] = (remaining[i] > 0);
`ifdef GFX_BUS_LOCK_EN
        if (remaining[i] == 0) ch_lock[i] = 1'b0;
`endif
      end
      if (breq_prev && !breq) log_q.push_back(9);
      breq_prev = breq;
      if (lock_scn ? (mreq_out && !lock) : lock) lock_bad++;
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    lock_scn  = 1'b0;
    reset_n   = 1'b0;
    back      = 1'b1;
    ack_delay = 2;
    ch_read   = '1;
    ch_addr   = '0;
    ch_width  = '0;
    ch_wdata  = '0;
    data_in   = 64'hA5A5_A5A5_A5A5_A5A5;
`ifdef GFX_BUS_LOCK_EN
    ch_lock   = '0;
`endif
    for (int i = 0; i < NCH; i++) remaining[i] = 0;

    #1;
    check("rst_breq", 64'(breq), 64'd0);
    check("rst_oe", 64'({a_oe, width_oe, read_oe, mreq_oe, wdata_oe}), 64'd0);
    check("rst_done", 64'(ch_done), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_outs", 64'({mreq_out, read_out, lock}), 64'd0);

    // Single read on channel 1 with exact cycle timing.
    do_reset();
    ch_addr[1*AW +: AW]  = 24'h123456;
    ch_width[1*WW +: WW] = WidthDword;
    #1 post(1, 1);
    @(negedge clk);  // requester raises ch_req here
    @(negedge clk);
    check("rd_breq", 64'(breq), 64'd1);
    check("rd_req_no_oe", 64'(mreq_oe), 64'd0);
    @(negedge clk);
    check("rd_a_out", 64'(a_out), 64'h123456);
    check("rd_oes", 64'({a_oe, width_oe, read_oe, mreq_oe}), 64'hF);
    check("rd_read_out", 64'(read_out), 64'd1);
    check("rd_mreq", 64'(mreq_out), 64'd1);
    check("rd_width", 64'(width_out), 64'(WidthDword));
    check("rd_wdata_oe", 64'(wdata_oe), 64'd0);
    @(negedge clk);
    check("rd_no_early_done", 64'(ch_done), 64'd0);
    @(negedge clk);
    check("rd_done", 64'(ch_done), 64'b0010);
    check("rd_rdata", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("rd_mreq_gap", 64'(mreq_out), 64'd0);
    @(negedge clk);
    check("rd_rel_breq", 64'(breq), 64'd0);
    check("rd_rel_oe", 64'({a_oe, mreq_oe, wdata_oe}), 64'd0);
    check("rd_done_pulse", 64'(ch_done), 64'd0);
    repeat (2) @(negedge clk);
    exp_q = '{1, 9};
    check_log("rd_log");

    // Channels 0, 2, 3 in one ownership.
    do_reset();
    #1;
    post(0, 1);
    post(2, 1);
    post(3, 1);
    wait_idle("b023", 200);
    exp_q = '{0, 2, 3, 9};
    check_log("b023_log");

    // All four requesting continuously: burst limit splits ownerships.
    do_reset();
    #1;
    for (int i = 0; i < NCH; i++) post(i, 2);
    wait_idle("all4", 400);
    exp_q = '{0, 1, 2, 3, 9, 0, 1, 2, 3, 9};
    check_log("all4_log");

    // Channel 0 alone: ineligible in its own done cycle, so the bus is released.
    do_reset();
    #1 post(0, 2);
    wait_idle("solo0", 200);
    exp_q = '{0, 9, 0, 9};
    check_log("solo0_log");

    // Write on channel 3.
    do_reset();
    ch_read[3]              = 1'b0;
    ch_addr[3*AW +: AW]     = 24'hABCDEF;
    ch_width[3*WW +: WW]    = WidthByte;
    ch_wdata[3*DW +: DW]    = 64'h0123_4567_89AB_CDEF;
    ack_delay               = 1;
    #1 post(3, 1);
    wait_mreq("wr", 50);
    check("wr_wdata_oe", 64'(wdata_oe), 64'd1);
    check("wr_wdata", wdata_out, 64'h0123_4567_89AB_CDEF);
    check("wr_read_out", 64'(read_out), 64'd0);
    check("wr_a_out", 64'(a_out), 64'hABCDEF);
    check("wr_width", 64'(width_out), 64'(WidthByte));
    wait_idle("wr", 100);
    exp_q = '{3, 9};
    check_log("wr_log");
    ch_read[3] = 1'b1;

    // Grant removed during a cycle: cycle finishes, bus released, no further cycle.
    do_reset();
    ack_delay = 3;
    #1;
    post(0, 1);
    post(1, 1);
    wait_mreq("bk", 50);
    back = 1'b0;
    repeat (12) @(negedge clk);
    exp_q = '{0, 9};
    check_log("bk_log");
    check("bk_breq_held", 64'(breq), 64'd1);
    check("bk_no_cycle", 64'({mreq_oe, mreq_out}), 64'd0);
    back = 1'b1;
    wait_idle("bk", 100);
    exp_q = '{0, 9, 1, 9};
    check_log("bk_log2");

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    ack_delay = 6;
    #1 post(2, 1);
    wait_mreq("ar", 50);
    #2 reset_n = 1'b0;
    #1;
    check("ar_oe", 64'({a_oe, width_oe, read_oe, mreq_oe, wdata_oe}), 64'd0);
    check("ar_breq", 64'({breq, mreq_out}), 64'd0);
    remaining[2] = 0;
    repeat (2) @(negedge clk);
    log_q.delete();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("ar_no_done", 64'(log_q.size()), 64'd0);
    check("ar_rdata", rdata, 64'd0);

`ifdef GFX_BUS_LOCK_EN
    // Locked channel 0: six cycles in one ownership, lock high on each.
    do_reset();
    ack_delay  = 2;
    lock_scn   = 1'b1;
    ch_lock[0] = 1'b1;
    #1 post(0, 6);
    wait_idle("lk", 600);
    exp_q = '{0, 0, 0, 0, 0, 0, 9};
    check_log("lk_log");
    check("lk_lock_idle", 64'(lock), 64'd0);
    lock_scn = 1'b0;
`endif

    check("lock_behaviour", 64'(lock_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
